// File: rtl/path_replay_buffer.sv
// Path replay buffer: stacks node indices written during traceback and replays them source-first.
// Optional macro REPLAY_LOOP_EN: replay restarts from the source after each last beat while display_on stays high.
module path_replay_buffer #(
  parameter int NODE_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              sys_reset,
  input  logic              clr,
  input  logic              write_en,
  input  logic [NODE_W-1:0] index_in,
  input  logic              display_on,
  output logic              node_valid,
  input  logic              node_ready,
  output logic [NODE_W-1:0] node_idx,
  output logic              node_first,
  output logic              node_last,
  output logic [CNT_W-1:0]  path_len,
  output logic              overflow,
  output logic              replay_done,
  output logic              busy
);

  localparam int AW = CNT_W - 1;

  typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;

  state_t            r_state, w_next;
  logic [NODE_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_len;
  logic [AW-1:0]     r_rd;
  logic [NODE_W-1:0] r_last_wr;
  logic [NODE_W-1:0] r_idx;
  logic              r_overflow, r_valid, r_first, r_last, r_done, r_disp_q;

  logic              w_rise, w_fire, w_wr_ok, w_dup, w_full, w_accept, w_drop;
  logic [AW-1:0]     w_top, w_rd_dec;

  assign w_rise   = display_on & ~r_disp_q;
  assign w_fire   = r_valid & node_ready;
  assign w_wr_ok  = write_en & ~clr & (r_state != REPLAY);
  assign w_dup    = (r_len != '0) && (index_in == r_last_wr);
  assign w_full   = (r_len == CNT_W'(DEPTH));
  assign w_accept = w_wr_ok & ~w_dup & ~w_full;
  assign w_drop   = w_wr_ok & ~w_dup & w_full;
  assign w_top    = AW'(r_len - CNT_W'(1));
  assign w_rd_dec = r_rd - AW'(1);

  assign node_valid  = r_valid;
  assign node_idx    = r_idx;
  assign node_first  = r_first;
  assign node_last   = r_last;
  assign path_len    = r_len;
  assign overflow    = r_overflow;
  assign replay_done = r_done;
  assign busy        = (r_state == REPLAY);

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      REPLAY: begin
        if (clr || !display_on)
          w_next = IDLE;
        else if (w_fire && r_rd == '0) begin
`ifdef REPLAY_LOOP_EN
          w_next = REPLAY;
`else
          w_next = DONE;
`endif
        end
      end
      default: begin
        if (clr)
          w_next = IDLE;
        else if (w_rise)
          w_next = (r_len != '0) ? REPLAY : DONE;
      end
    endcase
  end

  // Storage array carries no reset; path_len alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_len[AW-1:0]] <= index_in;
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_len      <= '0;
      r_rd       <= '0;
      r_last_wr  <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_disp_q   <= 1'b0;
    end else begin
      r_disp_q <= display_on;
      r_done   <= 1'b0;
      if (clr) begin
        r_len      <= '0;
        r_overflow <= 1'b0;
        r_valid    <= 1'b0;
        r_first    <= 1'b0;
        r_last     <= 1'b0;
      end else begin
        if (w_accept) begin
          r_len     <= r_len + CNT_W'(1);
          r_last_wr <= index_in;
        end
        if (w_drop) r_overflow <= 1'b1;
        case (r_state)
          REPLAY: begin
            if (!display_on) begin
              r_valid <= 1'b0;
              r_first <= 1'b0;
              r_last  <= 1'b0;
            end else if (w_fire) begin
              if (r_rd == '0) begin
                r_done <= 1'b1;
`ifdef REPLAY_LOOP_EN
                r_rd    <= w_top;
                r_idx   <= r_mem[w_top];
                r_first <= 1'b1;
                r_last  <= (w_top == '0);
`else
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
`endif
              end else begin
                r_rd    <= w_rd_dec;
                r_idx   <= r_mem[w_rd_dec];
                r_first <= 1'b0;
                r_last  <= (w_rd_dec == '0);
              end
            end
          end
          default: begin
            // Replay starts from the most recently written node, which is the source.
            if (w_rise) begin
              if (r_len != '0) begin
                r_rd    <= w_top;
                r_idx   <= r_mem[w_top];
                r_valid <= 1'b1;
                r_first <= 1'b1;
                r_last  <= (w_top == '0);
              end else begin
                r_done <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_path_replay_buffer.sv
// Directed self-checking bench for path_replay_buffer (default single-pass build).
module tb_path_replay_buffer;

  logic       clk, sys_reset, clr, write_en, display_on, node_ready;
  logic [4:0] index_in;
  logic       node_valid, node_first, node_last, overflow, replay_done, busy;
  logic [4:0] node_idx;
  logic [5:0] path_len;

  int total = 0;
  int bad   = 0;

  path_replay_buffer dut (
    .clk(clk), .sys_reset(sys_reset), .clr(clr), .write_en(write_en),
    .index_in(index_in), .display_on(display_on), .node_valid(node_valid),
    .node_ready(node_ready), .node_idx(node_idx), .node_first(node_first),
    .node_last(node_last), .path_len(path_len), .overflow(overflow),
    .replay_done(replay_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 ns after the rising edge that samples them.
  task automatic applyStimulus(input logic we, input logic [4:0] idx, input logic cl,
                               input logic disp, input logic rdy);
    write_en   = we;
    index_in   = idx;
    clr        = cl;
    display_on = disp;
    node_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    sys_reset = 1'b0; clr = 1'b0; write_en = 1'b0; index_in = '0;
    display_on = 1'b0; node_ready = 1'b0;
    #12;
    checkOutput("rst_len", path_len, 0);
    checkOutput("rst_valid", node_valid, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", replay_done, 0);
    checkOutput("rst_idx", node_idx, 0);
    sys_reset = 1'b1;

    // Duplicate suppression and basic source-first replay
    $display("[TB] writes 7,7,3,3,0 and free-running replay");
    applyStimulus(1, 7, 0, 0, 0);
    applyStimulus(1, 7, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t1_len", path_len, 3);
    checkOutput("t1_ovf", overflow, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_b0_valid", node_valid, 1);
    checkOutput("t1_b0_idx", node_idx, 0);
    checkOutput("t1_b0_first", node_first, 1);
    checkOutput("t1_b0_last", node_last, 0);
    checkOutput("t1_busy", busy, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_b1_idx", node_idx, 3);
    checkOutput("t1_b1_first", node_first, 0);
    checkOutput("t1_b1_last", node_last, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_b2_idx", node_idx, 7);
    checkOutput("t1_b2_last", node_last, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_end_valid", node_valid, 0);
    checkOutput("t1_end_done", replay_done, 1);
    checkOutput("t1_end_busy", busy, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t1_done_pulse", replay_done, 0);
    checkOutput("t1_len_kept", path_len, 3);

    $display("[TB] replay with stalling renderer");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_b0_idx", node_idx, 0);
    checkOutput("t2_b0_first", node_first, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t2_b1_idx", node_idx, 3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_stall1_idx", node_idx, 3);
    checkOutput("t2_stall1_valid", node_valid, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_stall2_idx", node_idx, 3);
    checkOutput("t2_stall2_first", node_first, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t2_b2_idx", node_idx, 7);
    checkOutput("t2_b2_last", node_last, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t2_end_valid", node_valid, 0);
    checkOutput("t2_end_done", replay_done, 1);

    $display("[TB] abort by display_on drop");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t5_b0_idx", node_idx, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_abort_valid", node_valid, 0);
    checkOutput("t5_abort_busy", busy, 0);
    checkOutput("t5_abort_done", replay_done, 0);
    checkOutput("t5_abort_len", path_len, 3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t5_rerun_valid", node_valid, 1);
    checkOutput("t5_rerun_idx", node_idx, 0);
    checkOutput("t5_rerun_first", node_first, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_abort2_done", replay_done, 0);

    $display("[TB] fill to capacity and overflow");
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t3_clr_len", path_len, 0);
    for (int i = 0; i < 32; i++) applyStimulus(1, 5'(i), 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    checkOutput("t3_full_len", path_len, 32);
    checkOutput("t3_ovf", overflow, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t3_b0_idx", node_idx, 31);
    checkOutput("t3_b0_first", node_first, 1);
    for (int k = 30; k >= 0; k--) begin
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("t3_seq_idx", node_idx, k);
    end
    checkOutput("t3_last", node_last, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t3_end_done", replay_done, 1);
    checkOutput("t3_ovf_sticky", overflow, 1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("t3_clr_len2", path_len, 0);
    checkOutput("t3_clr_ovf", overflow, 0);

    $display("[TB] clr beats write, empty replay");
    applyStimulus(1, 9, 1, 0, 0);
    checkOutput("t4_len", path_len, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t4_done", replay_done, 1);
    checkOutput("t4_valid", node_valid, 0);
    checkOutput("t4_busy", busy, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t4_done_pulse", replay_done, 0);
    checkOutput("t4_valid2", node_valid, 0);

    $display("[TB] asynchronous reset mid-replay");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t6_b0_idx", node_idx, 2);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t6_b1_idx", node_idx, 1);
    sys_reset = 1'b0;
    #1;
    checkOutput("t6_rst_valid", node_valid, 0);
    checkOutput("t6_rst_len", path_len, 0);
    checkOutput("t6_rst_busy", busy, 0);
    display_on = 1'b0;
    #2;
    sys_reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_post_valid", node_valid, 0);
    checkOutput("t6_post_len", path_len, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_replay_buffer.md
Name: path_replay_buffer

Overview:
- Receiving end of the path-write interface driven by the top-level control FSM.
- During traceback the FSM writes node indices in destination-to-source order, using write_en, index and clr.
- This block captures those indices in a stack, then replays them source-first over a valid/ready stream when display is enabled.
- It sits between the control FSM and the VGA path renderer.

Parameters:
- NODE_W, 5, width of a node index.
- DEPTH, 32, maximum number of stored path nodes; must be a power of 2 and at most 2^NODE_W.
- CNT_W, 6, width of the count and pointers; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock (50 MHz domain); everything is synchronous to its rising edge.
- sys_reset  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of stored path; held high by the FSM during destination entry.
- write_en  in  1  write strobe; index_in is sampled every cycle this is high.
- index_in  in  NODE_W  node index written by the FSM.
- display_on  in  1  level; a rising edge starts replay.
- node_valid  out  1  replay data valid.
- node_ready  in  1  renderer accepts node_idx.
- node_idx  out  NODE_W  replayed node index.
- node_first  out  1  marks the first replayed node (the source).
- node_last  out  1  marks the last replayed node (the destination).
- path_len  out  CNT_W  number of stored nodes.
- overflow  out  1  sticky flag: a write was dropped because the buffer was full.
- replay_done  out  1  one-cycle pulse when a replay pass ends.
- busy  out  1  high while in REPLAY.

Behaviour:
- Reset (sys_reset=0, asynchronous) forces:
  - state=IDLE
  - path_len=0, overflow=0
  - node_valid=0, node_first=0, node_last=0, node_idx=0
  - replay_done=0, busy=0
  - display_on edge register=0
- States: IDLE, REPLAY, DONE.
- Write path (IDLE or DONE only; write_en is ignored in REPLAY):
  - A write is accepted when write_en=1 and clr=0.
  - An accepted write stores index_in at mem[path_len], increments path_len, and records last_written.
  - Duplicate suppression: if path_len>0 and index_in==last_written, the write is ignored. This absorbs the FSM repeating the terminal node.
  - Full: if path_len==DEPTH and the write is not a duplicate, data is dropped and overflow is set. overflow clears only on clr or reset.
- clr=1 (any state):
  - path_len=0, overflow=0.
  - node_valid, node_first and node_last drop next cycle; state goes to IDLE.
  - clr has priority over write_en and over a display_on edge in the same cycle.
- Replay start:
  - A display_on rising edge (registered previous value 0, current 1) in IDLE or DONE, with path_len>0, enters REPLAY.
  - Rd pointer is set to path_len-1.
  - node_valid=1 on the next cycle with node_idx=mem[path_len-1] and node_first=1.
- Rising edge with path_len==0: go to DONE; replay_done pulses the next cycle; node_valid stays 0.
- REPLAY handshake:
  - node_idx, node_first and node_last stay stable while node_valid=1 and node_ready=0.
  - On node_valid and node_ready both 1: if rd==0, node_valid drops, replay_done pulses, and state goes to DONE. Otherwise rd decrements and the next node is presented the following cycle with no bubble.
  - node_last=1 exactly when rd==0.
  - A single-node path asserts node_first and node_last together.
- display_on falling mid-replay: the replay is aborted.
  - Next cycle node_valid=0 and state=IDLE.
  - No replay_done pulse.
  - Stored contents are kept.
- DONE: contents are kept. A new display_on rising edge replays again (non-destructive); clr empties the buffer.
- busy = (state==REPLAY).

Optional Feature:
- Macro: REPLAY_LOOP_EN.
- Defined: in REPLAY, the handshake of the node_last beat pulses replay_done and reloads rd=path_len-1, so the next node (with node_first=1) follows with no bubble. Looping continues while display_on=1; display_on falling ends it as an abort.
- Not defined: single pass, as described above.

Test Plan:
- Writes 7,7,3,3,0 then display_on rise, node_ready=1 -> path_len=3; stream 0(first),3,7(last); replay_done one cycle after the last beat.
- Replay with node_ready toggling 1,0,0,1,1 -> each node held stable while stalled, no loss or duplication, order 0,3,7.
- 33 distinct writes 0..31 then 5 -> path_len=32, overflow=1; replay gives 31 down to 0; clr -> path_len=0, overflow=0.
- clr and write_en together with index 9 -> path_len=0; display_on rise with empty buffer -> replay_done pulse, node_valid never 1.
- sys_reset low mid-replay after 1 beat -> node_valid=0, path_len=0 immediately (asynchronous); display_on drop mid-replay (no reset) -> IDLE, no replay_done, path_len unchanged, second display_on rise replays from node_first.
- With REPLAY_LOOP_EN, path 0,3,7 and display_on held for 8 beats -> 0,3,7,0,3,7,0,3 with replay_done after each 7.
